// File: rtl/irq_ctl_if.sv
// Core-side bus and interrupt handshake seen by the interrupt controller.
// The slave modport is the controller; the master modport is the core/testbench side.
interface irq_ctl_if #(
    parameter int unsigned NSRC = 8
);
    logic [31:0]     addr_i;
    logic [31:0]     din_i;
    logic [3:0]      wr_en_i;
    logic [31:0]     dout_o;
    logic [NSRC-1:0] irq_src_i;
    logic            irq_o;
    logic [31:0]     irq_addr_o;
    logic            iack_i;

    modport slave (
        input  addr_i, din_i, wr_en_i, irq_src_i, iack_i,
        output dout_o, irq_o, irq_addr_o
    );

    modport master (
        output addr_i, din_i, wr_en_i, irq_src_i, iack_i,
        input  dout_o, irq_o, irq_addr_o
    );
endinterface

// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller: latches source edges, prioritises the lowest
// enabled index, and holds one request to the core until acknowledged.
module irq_ctl #(
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int unsigned VEC_SHIFT = 4,
    parameter logic [31:0] RST_VEC   = 32'h0000_0050
) (
    input logic       clk,
    input logic       rst,
    irq_ctl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, INSRV} state_t;

    localparam logic [31:0] VMASK = ~((32'd1 << VEC_SHIFT) - 32'd1);

    state_t          state, state_nxt;
    logic [NSRC-1:0] pend, mask, src_d, edge_v, elig, w1c, ack_clr;
    logic [31:0]     vbase, bmask, rdata, irq_addr_nxt;
    logic [3:0]      win, cur_idx;
    logic [4:0]      off;
    logic            hit, wr, have, ack, eoi, irq_nxt;

    assign hit  = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
    assign off  = bus.addr_i[4:0];
    assign wr   = hit && (bus.wr_en_i != 4'b0);
    assign edge_v = bus.irq_src_i & ~src_d;
    assign elig = pend & mask;
    assign have = |elig;

    for (genvar b = 0; b < 4; b++) begin : g_bmask
        assign bmask[8*b +: 8] = {8{bus.wr_en_i[b]}};
    end

    // Descending scan so the lowest set index is the last one assigned
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) win = 4'(i);
    end

    assign ack     = (state == REQ) && have && bus.iack_i;
    assign eoi     = wr && (off == 5'h10) && (state == INSRV);
    assign w1c     = (wr && off == 5'h00) ? (bmask[NSRC-1:0] & bus.din_i[NSRC-1:0]) : '0;
    assign ack_clr = ack ? (NSRC'(1) << win) : '0;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                5'h00:   rdata = 32'(pend);
                5'h04:   rdata = 32'(mask);
                5'h08:   rdata = vbase;
                5'h0C:   rdata = {(state == INSRV), 27'b0, cur_idx};
                default: rdata = '0;
            endcase
        end
    end

    // FSM: state register plus registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.irq_o      <= 1'b0;
            bus.irq_addr_o <= RST_VEC;
        end else begin
            state          <= state_nxt;
            bus.irq_o      <= irq_nxt;
            bus.irq_addr_o <= irq_addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (have) state_nxt = REQ;
            REQ:     if (!have) state_nxt = IDLE;
                     else if (bus.iack_i) state_nxt = INSRV;
            INSRV:   if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector tracks the current winner while requesting, otherwise holds
    always_comb begin
        irq_nxt      = (state_nxt == REQ);
        irq_addr_nxt = bus.irq_addr_o;
        if (state_nxt == REQ)
            irq_addr_nxt = vbase + (32'(win) << VEC_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            mask       <= '0;
            vbase      <= RST_VEC;
            src_d      <= '0;
            cur_idx    <= '0;
            bus.dout_o <= '0;
        end else begin
            src_d      <= bus.irq_src_i;
            bus.dout_o <= rdata;
            // New edges override a same-cycle W1C or acknowledge clear
            pend       <= (pend & ~w1c & ~ack_clr) | edge_v;
            if (ack) cur_idx <= win;
            if (wr && off == 5'h04)
                mask <= (mask & ~bmask[NSRC-1:0]) | (bus.din_i[NSRC-1:0] & bmask[NSRC-1:0]);
            if (wr && off == 5'h08)
                vbase <= ((vbase & ~bmask) | (bus.din_i & bmask)) & VMASK;
        end
    end
endmodule

// File: tb/tb_irq_ctl.sv
// Directed plus randomized bench for irq_ctl, checked against a cycle-level
// behavioural model of the register block and request handshake.
module tb_irq_ctl;
    localparam int NSRC = 12;
    localparam logic [31:0] BASE = 32'h0000_F000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    irq_ctl_if #(.NSRC(NSRC)) bif ();

    irq_ctl #(.NSRC(NSRC), .BASE_ADDR(BASE), .VEC_SHIFT(4), .RST_VEC(32'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // behavioural model state
    bit [NSRC-1:0] m_pend, m_mask, m_srcd;
    bit [31:0]     m_vbase, m_dout, m_irq_addr;
    bit            m_req, m_srv;
    int            m_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_read(input bit hit, input bit [4:0] off);
        if (!hit) return 32'h0;
        case (off)
            5'h00:   return 32'(m_pend);
            5'h04:   return 32'(m_mask);
            5'h08:   return m_vbase;
            5'h0C:   return {m_srv, 27'b0, 4'(m_cur)};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock with the inputs currently driven, then compare.
    task automatic tick();
        bit [31:0] bm, new_addr;
        bit [NSRC-1:0] el, edg;
        bit [4:0] off;
        bit hit, wr;
        int w;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_srcd = '0; m_vbase = 32'h50;
            m_dout = '0; m_irq_addr = 32'h50; m_req = 0; m_srv = 0; m_cur = 0;
        end else begin
            hit = (bif.addr_i[31:5] == BASE[31:5]);
            off = bif.addr_i[4:0];
            wr  = hit && (bif.wr_en_i != 0);
            bm  = '0;
            for (int b = 0; b < 4; b++)
                if (bif.wr_en_i[b]) bm |= 32'hFF << (8 * b);
            m_dout = model_read(hit, off);
            el = m_pend & m_mask;
            w = -1;
            for (int i = 0; i < NSRC; i++)
                if (el[i] && w < 0) w = i;
            new_addr = m_vbase + 32'(w * 16);
            edg = bif.irq_src_i & ~m_srcd;
            m_srcd = bif.irq_src_i;
            if (wr && off == 5'h00) m_pend &= ~NSRC'(bif.din_i & bm);
            if (wr && off == 5'h04) m_mask = (m_mask & ~NSRC'(bm)) | NSRC'(bif.din_i & bm);
            if (wr && off == 5'h08) m_vbase = ((m_vbase & ~bm) | (bif.din_i & bm)) & ~32'hF;
            if (m_req) begin
                if (w < 0) m_req = 0;
                else if (bif.iack_i) begin
                    m_req = 0; m_srv = 1; m_cur = w; m_pend[w] = 1'b0;
                end
            end else if (m_srv) begin
                if (wr && off == 5'h10) m_srv = 0;
            end else if (w >= 0) begin
                m_req = 1;
            end
            m_pend |= edg;
            if (m_req) m_irq_addr = new_addr;
        end
        @(posedge clk);
        #1;
        chk("dout", bif.dout_o, m_dout);
        chk("irq", 32'(bif.irq_o), 32'(m_req));
        chk("irq_addr", bif.irq_addr_o, m_irq_addr);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bif.addr_i = a; bif.din_i = d; bif.wr_en_i = we;
        tick();
        bif.wr_en_i = 4'b0; bif.din_i = '0;
    endtask

    initial begin
        bif.addr_i = '0; bif.din_i = '0; bif.wr_en_i = '0;
        bif.irq_src_i = '0; bif.iack_i = 1'b0;

        // reset values and read latency
        rst = 1'b1; tick();
        chk("rst_irq", 32'(bif.irq_o), 32'h0);
        chk("rst_vec", bif.irq_addr_o, 32'h50);
        rst = 1'b0;
        bif.addr_i = BASE + 32'h4; tick(); chk("rd_mask", bif.dout_o, 32'h0);
        bif.addr_i = BASE + 32'h8; tick(); chk("rd_vbase", bif.dout_o, 32'h50);

        // single source, two-cycle latency, acknowledge
        bus_wr(BASE + 32'h4, 32'hFF, 4'hF);
        bif.irq_src_i = 12'h008; tick(); chk("lat1_irq", 32'(bif.irq_o), 32'h0);
        tick();
        chk("lat2_irq", 32'(bif.irq_o), 32'h1);
        chk("vec3", bif.irq_addr_o, 32'h80);
        bif.iack_i = 1'b1; tick(); bif.iack_i = 1'b0;
        chk("ack_irq", 32'(bif.irq_o), 32'h0);
        bif.addr_i = BASE + 32'hC; tick(); chk("cur3", bif.dout_o, 32'h8000_0003);

        // priority between simultaneous sources, EOI re-request
        bif.irq_src_i = '0;
        bus_wr(BASE + 32'h10, 32'h0, 4'hF);
        bif.irq_src_i = 12'h024; tick(); tick();
        chk("prio_irq", 32'(bif.irq_o), 32'h1);
        chk("vec2", bif.irq_addr_o, 32'h70);
        bif.iack_i = 1'b1; tick(); bif.iack_i = 1'b0;
        bus_wr(BASE + 32'h10, 32'h0, 4'hF);
        chk("eoi_irq", 32'(bif.irq_o), 32'h0);
        tick();
        chk("rereq_irq", 32'(bif.irq_o), 32'h1);
        chk("vec5", bif.irq_addr_o, 32'hA0);

        // masking while requesting withdraws the request but keeps PEND
        bus_wr(BASE + 32'h4, 32'h0, 4'hF);
        bif.addr_i = BASE; tick();
        chk("mask_irq", 32'(bif.irq_o), 32'h0);
        chk("mask_pend", bif.dout_o, 32'h20);

        // edge beats W1C; byte enables; bits above NSRC ignored
        bif.irq_src_i = '0; tick();
        bif.irq_src_i = 12'h001;
        bus_wr(BASE, 32'h1, 4'hF);
        tick(); chk("set_wins", bif.dout_o, 32'h21);
        bus_wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'b0010);
        tick(); chk("mask_byte1", bif.dout_o, 32'h0F00);
        bus_wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'b0001);
        tick();
        chk("mask_full", bif.dout_o, 32'h0FFF);
        chk("vec0", bif.irq_addr_o, 32'h50);
        bif.iack_i = 1'b1; tick(); bif.iack_i = 1'b0;
        bif.addr_i = BASE + 32'hC; tick(); chk("cur0", bif.dout_o, 32'h8000_0000);

        // reset during service, then iack in IDLE
        rst = 1'b1; tick();
        chk("rst2_irq", 32'(bif.irq_o), 32'h0);
        chk("rst2_dout", bif.dout_o, 32'h0);
        rst = 1'b0;
        bif.iack_i = 1'b1; tick(); tick(); bif.iack_i = 1'b0;
        chk("idle_iack", bif.dout_o, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 12)      bif.addr_i = BASE + 32'(4 * $urandom_range(0, 5));
            else if (r < 14) bif.addr_i = BASE + 32'($urandom_range(0, 31));
            else             bif.addr_i = $urandom;
            bif.din_i   = $urandom;
            bif.wr_en_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            bif.irq_src_i = bif.irq_src_i ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
            bif.iack_i  = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
